uart_fifo_ctrl: RTL and testbench

Parametrised full-duplex UART with a synchronous TX FIFO and RX FIFO on one clock domain.
Successor to the fixed 8-bit, mode-table UART/FIFO top:
- data width, FIFO depth and baud divisor are generalised;
- adds framing-error detection and overflow detection;
- uses valid/ready handshakes at the parallel side.
It sits between the system bus logic and the serial pins.

---
 rtl/uart_fifo_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: full-duplex UART with show-ahead TX and RX FIFOs on one clock.
// Frames are start + DATA_W bits LSB first + stop; baud_div below 4 acts as 4.
// Optional build macro UART_PARITY_EN adds a parity bit (PARITY_ODD selects odd).
module uart_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int DIV_W  = 16
`ifdef UART_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic [AW:0]       tx_count,
    output logic [AW:0]       rx_count,
    output logic              frame_err,
    output logic              rx_overflow,
    output logic              parity_err,
    input  logic              clr_err
);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DIV_W-1:0] eff_div;
    assign eff_div = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [AW-1:0]     tx_wp_q, tx_rp_q;
    logic [AW:0]       tx_cnt_q;
    logic              tx_push, tx_pop;

    assign tx_ready = (tx_cnt_q != FULL);
    assign tx_push  = tx_valid && tx_ready;
    assign tx_count = tx_cnt_q;

    // TX storage write
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= tx_data;
    end

    // TX pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            tx_cnt_q <= tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t         tx_st_q, tx_st_d;
    logic [DIV_W-1:0]  tx_div_q, tx_div_d, tx_tmr_q, tx_tmr_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic              tx_bit_end;
`ifdef UART_PARITY_EN
    logic              tx_par_q, tx_par_d;
`endif

    assign tx_bit_end = (tx_tmr_q == tx_div_q - 1'b1);

    // TX state register
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st_q  <= TX_IDLE;
            tx_div_q <= DIV_W'(4);
            tx_tmr_q <= '0;
            tx_sh_q  <= '0;
            tx_bit_q <= '0;
`ifdef UART_PARITY_EN
            tx_par_q <= 1'b0;
`endif
        end else begin
            tx_st_q  <= tx_st_d;
            tx_div_q <= tx_div_d;
            tx_tmr_q <= tx_tmr_d;
            tx_sh_q  <= tx_sh_d;
            tx_bit_q <= tx_bit_d;
`ifdef UART_PARITY_EN
            tx_par_q <= tx_par_d;
`endif
        end
    end

    // TX next state, FIFO pop and line level
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_div_d = tx_div_q;
        tx_tmr_d = tx_bit_end ? '0 : tx_tmr_q + 1'b1;
        tx_sh_d  = tx_sh_q;
        tx_bit_d = tx_bit_q;
`ifdef UART_PARITY_EN
        tx_par_d = tx_par_q;
`endif
        tx_pop   = 1'b0;
        uart_tx  = 1'b1;
        case (tx_st_q)
            TX_IDLE: begin
                tx_tmr_d = '0;
                if (tx_cnt_q != '0) begin
                    tx_pop   = 1'b1;
                    tx_sh_d  = tx_mem[tx_rp_q];
                    tx_div_d = eff_div;
                    tx_bit_d = '0;
`ifdef UART_PARITY_EN
                    tx_par_d = (^tx_mem[tx_rp_q]) ^ PARITY_ODD;
`endif
                    tx_st_d  = TX_START;
                end
            end
            TX_START: begin
                uart_tx = 1'b0;
                if (tx_bit_end) tx_st_d = TX_DATA;
            end
            TX_DATA: begin
                uart_tx = tx_sh_q[0];
                if (tx_bit_end) begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = tx_bit_q + 1'b1;
                    if (tx_bit_q == 4'(DATA_W-1)) begin
`ifdef UART_PARITY_EN
                        tx_st_d = TX_PAR;
`else
                        tx_st_d = TX_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PAR: begin
                uart_tx = tx_par_q;
                if (tx_bit_end) tx_st_d = TX_STOP;
            end
`endif
            TX_STOP: begin
                if (tx_bit_end) tx_st_d = TX_IDLE;
            end
            default: tx_st_d = TX_IDLE;
        endcase
    end

    // ---------------- RX synchroniser ----------------
    logic rx_s1_q, rx_s2_q, rx_s3_q;

    // Two-flop synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= uart_rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t         rx_st_q, rx_st_d;
    logic [DIV_W-1:0]  rx_div_q, rx_div_d, rx_tmr_q, rx_tmr_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [3:0]        rx_bit_q, rx_bit_d;
    logic              rx_tick, rx_push_req, fe_set;
`ifdef UART_PARITY_EN
    logic              rx_par_q, rx_par_d, pe_set;
`endif

    // rx_tmr restarts at 1 after each sample so the next sample lands div clocks later
    assign rx_tick = (rx_tmr_q == rx_div_q);

    // RX state register
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_st_q  <= RX_IDLE;
            rx_div_q <= DIV_W'(4);
            rx_tmr_q <= '0;
            rx_sh_q  <= '0;
            rx_bit_q <= '0;
`ifdef UART_PARITY_EN
            rx_par_q <= 1'b0;
`endif
        end else begin
            rx_st_q  <= rx_st_d;
            rx_div_q <= rx_div_d;
            rx_tmr_q <= rx_tmr_d;
            rx_sh_q  <= rx_sh_d;
            rx_bit_q <= rx_bit_d;
`ifdef UART_PARITY_EN
            rx_par_q <= rx_par_d;
`endif
        end
    end

    // RX next state, byte delivery and error detection
    always_comb begin
        rx_st_d     = rx_st_q;
        rx_div_d    = rx_div_q;
        rx_tmr_d    = rx_tmr_q + 1'b1;
        rx_sh_d     = rx_sh_q;
        rx_bit_d    = rx_bit_q;
        rx_push_req = 1'b0;
        fe_set      = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_d    = rx_par_q;
        pe_set      = 1'b0;
`endif
        case (rx_st_q)
            RX_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_div_d = eff_div;
                    rx_tmr_d = DIV_W'(1);
                    rx_st_d  = RX_START;
                end
            end
            RX_START: begin
                if (rx_tmr_q == (rx_div_q >> 1)) begin
                    rx_tmr_d = DIV_W'(1);
                    rx_bit_d = '0;
                    rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_tmr_d = DIV_W'(1);
                    rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
                    rx_bit_d = rx_bit_q + 1'b1;
                    if (rx_bit_q == 4'(DATA_W-1)) begin
`ifdef UART_PARITY_EN
                        rx_st_d = RX_PAR;
`else
                        rx_st_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PAR: begin
                if (rx_tick) begin
                    rx_tmr_d = DIV_W'(1);
                    rx_par_d = rx_s2_q;
                    rx_st_d  = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_tick) begin
                    if (!rx_s2_q) begin
                        fe_set  = 1'b1;
                        rx_st_d = RX_WAIT;
                    end else begin
`ifdef UART_PARITY_EN
                        if (rx_par_q != ((^rx_sh_q) ^ PARITY_ODD)) pe_set = 1'b1;
                        else rx_push_req = 1'b1;
`else
                        rx_push_req = 1'b1;
`endif
                        rx_st_d = RX_IDLE;
                    end
                end
            end
            RX_WAIT: begin
                if (rx_s2_q) rx_st_d = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] rx_mem [DEPTH];
    logic [AW-1:0]     rx_wp_q, rx_rp_q;
    logic [AW:0]       rx_cnt_q;
    logic              rx_pop, rx_push, ovf_set;
    logic              frame_err_q, rx_ovf_q;

    assign rx_valid = (rx_cnt_q != '0);
    assign rx_pop   = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign rx_push  = rx_push_req && ((rx_cnt_q != FULL) || rx_pop);
    assign ovf_set  = rx_push_req && (rx_cnt_q == FULL) && !rx_pop;
    assign rx_data  = rx_valid ? rx_mem[rx_rp_q] : '0;
    assign rx_count = rx_cnt_q;

    // RX storage write
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
    end

    // RX pointers, occupancy and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            rx_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            rx_ovf_q    <= 1'b0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            rx_cnt_q    <= rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
            frame_err_q <= fe_set;
            if (ovf_set)      rx_ovf_q <= 1'b1;
            else if (clr_err) rx_ovf_q <= 1'b0;
        end
    end

    assign frame_err   = frame_err_q;
    assign rx_overflow = rx_ovf_q;

`ifdef UART_PARITY_EN
    logic parity_err_q;

    // Parity error pulse register
    always_ff @(posedge clk) begin
        if (rst) parity_err_q <= 1'b0;
        else     parity_err_q <= pe_set;
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Testbench for uart_fifo_ctrl: TX waveform check, loopback scoreboard,
// RX overflow, glitch/framing errors, TX full and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_fifo_ctrl;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int DIV_W  = 16;
`ifdef UART_PARITY_EN
    localparam int NB = DATA_W + 3;
`else
    localparam int NB = DATA_W + 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DIV_W-1:0]  baud_div;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              uart_rx;
    logic              uart_tx;
    logic [AW:0]       tx_count;
    logic [AW:0]       rx_count;
    logic              frame_err;
    logic              rx_overflow;
    logic              parity_err;
    logic              clr_err;
    logic              loop_en;
    logic              rx_drv;

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    always #5 clk = ~clk;

    uart_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .uart_rx(uart_rx), .uart_tx(uart_tx),
        .tx_count(tx_count), .rx_count(rx_count),
        .frame_err(frame_err), .rx_overflow(rx_overflow),
        .parity_err(parity_err), .clr_err(clr_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt   = 0;
    int pe_cnt   = 0;

    // Count error pulse cycles
    always @(negedge clk) begin
        if (frame_err)  fe_cnt++;
        if (parity_err) pe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference frame, bit 0 first on the line: start, data LSB first, [parity], stop
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic stop);
`ifdef UART_PARITY_EN
        frame_bits = {5'b0, stop, ^d, d, 1'b0};
`else
        frame_bits = {6'b0, stop, d, 1'b0};
`endif
    endfunction

    task automatic send_bits(input logic [15:0] bits, input int div);
        for (int i = 0; i < NB; i++) begin
            rx_drv = bits[i];
            tick(div);
        end
        rx_drv = 1'b1;
    endtask

    // Push one byte and compare every cycle of the serial frame with the reference
    task automatic tx_wave(input logic [7:0] d, input int div_in);
        int de;
        logic [15:0] fb;
        de = (div_in < 4) ? 4 : div_in;
        fb = frame_bits(d, 1'b1);
        baud_div = DIV_W'(div_in);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_cnt_push", tx_count, 1);
        chk("tx_line_pre", uart_tx, 1);
        @(negedge clk);
        chk("tx_cnt_start", tx_count, 0);
        for (int c = 0; c < NB * de; c++) begin
            chk("tx_wave", uart_tx, fb[c / de]);
            @(negedge clk);
        end
        chk("tx_idle_after", uart_tx, 1);
    endtask

    logic [7:0] q[$];
    logic [7:0] fixed_b [3];
    logic [7:0] b;
    logic [15:0] fb;
    int sent, peak, fe0, d;
    bit rr;

    initial begin
        rst = 1'b1; baud_div = 16'd8; tx_data = '0; tx_valid = 1'b0;
        rx_ready = 1'b0; clr_err = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
        fixed_b[0] = 8'h00; fixed_b[1] = 8'hFF; fixed_b[2] = 8'h3C;
        tick(3);
        rst = 1'b0;

        // Reset state
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_tx_count", tx_count, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overflow", rx_overflow, 0);
        chk("rst_parity_err", parity_err, 0);

        // TX waveforms: fixed pattern, clamped divisor, random divisor
        tx_wave(8'hA5, 8);
        tx_wave(8'($urandom), 2);
        tx_wave(8'($urandom), $urandom_range(5, 9));

        // Loopback with random handshakes against a byte queue
        loop_en  = 1'b1;
        baud_div = DIV_W'($urandom_range(8, 12));
        fe0 = fe_cnt; sent = 0; peak = 0; q.delete();
        for (int cyc = 0; cyc < 6000 && (sent < 12 || q.size() > 0); cyc++) begin
            @(negedge clk);
            if (int'(rx_count) > peak) peak = int'(rx_count);
            rr = ($urandom_range(0, 9) < 7);
            if (rr && rx_valid) begin
                if (q.size() == 0) chk("lb_extra", rx_valid, 0);
                else begin
                    chk("lb_data", rx_data, q[0]);
                    void'(q.pop_front());
                end
            end
            rx_ready = rr;
            if (sent < 12 && (sent < 3 || $urandom_range(0, 1) == 1)) begin
                tx_data  = (sent < 3) ? fixed_b[sent] : 8'($urandom);
                tx_valid = 1'b1;
                if (tx_ready) begin
                    q.push_back(tx_data);
                    sent++;
                end
            end else tx_valid = 1'b0;
        end
        @(negedge clk);
        tx_valid = 1'b0; rx_ready = 1'b0;
        chk("lb_sent", sent, 12);
        chk("lb_drained", q.size(), 0);
        chk("lb_frame_err", fe_cnt - fe0, 0);
        chk("lb_overflow", rx_overflow, 0);
        chk("lb_peak_le3", peak <= 3, 1);
        tick(2 * 12 * NB);
        loop_en = 1'b0;

        // RX overflow: 16 frames fill the FIFO, the 17th is dropped
        d = $urandom_range(8, 12);
        baud_div = DIV_W'(d);
        q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            send_bits(frame_bits(b, 1'b1), d);
        end
        tick(2);
        chk("ovf_count16", rx_count, 16);
        chk("ovf_not_yet", rx_overflow, 0);
        send_bits(frame_bits(8'h5A, 1'b1), d);
        tick(2);
        chk("ovf_count_held", rx_count, 16);
        chk("ovf_set", rx_overflow, 1);
        rx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_readback", rx_data, q[i]);
            @(negedge clk);
        end
        rx_ready = 1'b0;
        chk("ovf_empty", rx_valid, 0);
        chk("ovf_sticky", rx_overflow, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("ovf_cleared", rx_overflow, 0);

        // Start-bit glitch, then a frame with a bad stop bit, then resync
        baud_div = 16'd16;
        fe0 = fe_cnt;
        rx_drv = 1'b0; tick(2); rx_drv = 1'b1; tick(48);
        chk("glitch_count", rx_count, 0);
        chk("glitch_fe", fe_cnt - fe0, 0);
        send_bits(frame_bits(8'($urandom), 1'b0), 16);
        tick(4);
        chk("fe_one_pulse", fe_cnt - fe0, 1);
        chk("fe_count", rx_count, 0);
        b = 8'($urandom);
        send_bits(frame_bits(b, 1'b1), 16);
        tick(2);
        chk("resync_count", rx_count, 1);
        chk("resync_data", rx_data, b);
        rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;

`ifdef UART_PARITY_EN
        // Parity: wrong parity bit dropped, correct one accepted
        baud_div = 16'd10;
        fe0 = fe_cnt;
        d = pe_cnt;
        fb = frame_bits(8'h07, 1'b1);
        fb[DATA_W+1] = ~fb[DATA_W+1];
        send_bits(fb, 10);
        tick(2);
        chk("par_pulse", pe_cnt - d, 1);
        chk("par_dropped", rx_count, 0);
        chk("par_no_fe", fe_cnt - fe0, 0);
        send_bits(frame_bits(8'h07, 1'b1), 10);
        tick(2);
        chk("par_ok_count", rx_count, 1);
        chk("par_ok_data", rx_data, 8'h07);
        rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
`else
        chk("parity_tied", pe_cnt, 0);
`endif

        // TX FIFO full and reset mid-DATA
        d = $urandom_range(20, 30);
        baud_div = DIV_W'(d);
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tick(3);
        chk("txf_busy_cnt", tx_count, 0);
        for (int k = 1; k <= DEPTH; k++) begin
            tx_data = 8'($urandom); tx_valid = 1'b1;
            @(negedge clk);
            chk("txf_count", tx_count, k);
            chk("txf_ready", tx_ready, k < DEPTH);
        end
        tx_data = 8'($urandom);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("txf_17th_ignored", tx_count, 16);
        chk("txf_ready_low", tx_ready, 0);
        tick(2 * d);
        chk("txf_mid_data", uart_tx, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_uart_tx", uart_tx, 1);
        chk("rst_mid_tx_count", tx_count, 0);
        chk("rst_mid_tx_ready", tx_ready, 1);
        tick(2 * d);
        chk("rst_mid_idle", uart_tx, 1);
        chk("rst_mid_still_empty", tx_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
